// File: rtl/rptr_empty_if.sv
// Read-side pointer/empty bus: consumer request, synchronized write pointer in;
// RAM read address, Gray read pointer, flags and level out.
interface rptr_empty_if #(
  parameter int unsigned AW = 3
);
  logic          r_en;
  logic [AW:0]   rsync_ptr2;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          r_empty;
  logic          r_underflow;
  logic [AW:0]   r_level;
  logic          r_aempty;

  // Consumer / synchronizer side
  modport master (
    output r_en, rsync_ptr2,
    input  raddr, rptr, r_empty, r_underflow, r_level, r_aempty
  );

  // Pointer/empty stage side
  modport slave (
    input  r_en, rsync_ptr2,
    output raddr, rptr, r_empty, r_underflow, r_level, r_aempty
  );
endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer and empty-flag stage of the async FIFO.
// Optional feature macro RD_LEVEL_EN: adds read-side fill level and a
// threshold-based almost-empty flag; without it r_level is 0 and r_aempty
// follows r_empty.
module rptr_empty #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic         r_clk,
  input  logic         rst_n,
  rptr_empty_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Out-of-range threshold leaves an empty marker block; no hardware cost.
  if (AEMPTY_THR == 0 || AEMPTY_THR >= DEPTH) begin : g_thr_out_of_range
  end

  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_q;
  logic          empty_q;
  logic          underflow_q;

  logic          rd_inc;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;

  // Next-state read pointer in binary and Gray
  always_comb begin
    rd_inc     = 1'b0;
    rbin_next  = rbin;
    rgray_next = '0;
    rd_inc     = bus.r_en & ~empty_q;
    rbin_next  = rbin + PW'(rd_inc);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  // Pointer, empty and underflow registers
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin        <= '0;
      rptr_q      <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rptr_q      <= rgray_next;
      empty_q     <= (rgray_next == bus.rsync_ptr2);
      underflow_q <= bus.r_en & empty_q;
    end
  end

  assign bus.raddr       = rbin[AW-1:0];
  assign bus.rptr        = rptr_q;
  assign bus.r_empty     = empty_q;
  assign bus.r_underflow = underflow_q;

`ifdef RD_LEVEL_EN
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic [PW-1:0] level_q;
  logic          aempty_q;

  // Gray-to-binary of the synchronized write pointer and occupancy
  always_comb begin
    wbin_s         = '0;
    level_next     = '0;
    wbin_s[PW-1]   = bus.rsync_ptr2[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ bus.rsync_ptr2[i];
    end
    level_next = wbin_s - rbin_next;
  end

  // Registered level and almost-empty flag
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      aempty_q <= 1'b1;
    end else begin
      level_q  <= level_next;
      aempty_q <= (level_next <= PW'(AEMPTY_THR));
    end
  end

  assign bus.r_level  = level_q;
  assign bus.r_aempty = aempty_q;
`else
  assign bus.r_level  = '0;
  assign bus.r_aempty = empty_q;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty (DEPTH=8): stimulus pushes hand-derived
// expectations tagged with the cycle they apply to; a negedge monitor pops
// and compares.
module tb_rptr_empty;

  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       empty;
    logic       uf;
    logic [3:0] level;
    logic       aempty;
  } obs_t;

  typedef struct {
    int   cyc;
    int   id;
    obs_t o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  bit   chk_gray = 1'b0;
  logic [3:0] prev_rptr = '0;
  exp_t sb[$];

  rptr_empty_if #(.AW(AW)) bus ();

  rptr_empty #(.DEPTH(8), .AEMPTY_THR(2)) dut (
    .r_clk (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic obs_t mk(input int raddr, input logic [3:0] rptr,
                              input logic empty, input logic uf, input int lvl);
    obs_t o;
    o.raddr = 3'(raddr);
    o.rptr  = rptr;
    o.empty = empty;
    o.uf    = uf;
`ifdef RD_LEVEL_EN
    o.level  = 4'(lvl);
    o.aempty = (lvl <= 2);
`else
    o.level  = 4'd0;
    o.aempty = empty;
`endif
    return o;
  endfunction

  function automatic void compare(input int id, input obs_t e);
    obs_t a;
    a.raddr  = bus.raddr;
    a.rptr   = bus.rptr;
    a.empty  = bus.r_empty;
    a.uf     = bus.r_underflow;
    a.level  = bus.r_level;
    a.aempty = bus.r_aempty;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL step%0d got raddr=%0d rptr=%b empty=%b uf=%b level=%0d aempty=%b want raddr=%0d rptr=%b empty=%b uf=%b level=%0d aempty=%b",
               id, a.raddr, a.rptr, a.empty, a.uf, a.level, a.aempty,
               e.raddr, e.rptr, e.empty, e.uf, e.level, e.aempty);
    end
  endfunction

  // Drive one cycle of inputs and queue the state expected after the next edge
  task automatic step(input logic en, input logic [3:0] wsync, input obs_t e);
    exp_t x;
    bus.r_en       = en;
    bus.rsync_ptr2 = wsync;
    step_id++;
    x.cyc = cyc + 1;
    x.id  = step_id;
    x.o   = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare outputs for expectations due this cycle
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      if (x.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_step%0d due cycle %0d seen at cycle %0d", x.id, x.cyc, cyc);
      end else begin
        compare(x.id, x.o);
      end
    end
    if (chk_gray) begin
      checks++;
      if ($countones(bus.rptr ^ prev_rptr) > 1) begin
        errors++;
        $display("FAIL gray_step got %b after %b want at most one bit change", bus.rptr, prev_rptr);
      end
    end
    prev_rptr = bus.rptr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rd;
    int w;
    bus.r_en       = 1'b0;
    bus.rsync_ptr2 = 4'b0000;
    #12;
    compare(0, mk(0, 4'b0000, 1'b1, 1'b0, 0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty reads: underflow each cycle, pointer holds
    repeat (3) step(1'b1, 4'b0000, mk(0, 4'b0000, 1'b1, 1'b1, 0));
    step(1'b0, 4'b0000, mk(0, 4'b0000, 1'b1, 1'b0, 0));

    // Drain three entries
    step(1'b0, 4'b0010, mk(0, 4'b0000, 1'b0, 1'b0, 3));
    step(1'b1, 4'b0010, mk(1, 4'b0001, 1'b0, 1'b0, 2));
    step(1'b1, 4'b0010, mk(2, 4'b0011, 1'b0, 1'b0, 1));
    step(1'b1, 4'b0010, mk(3, 4'b0010, 1'b1, 1'b0, 0));
    step(1'b1, 4'b0010, mk(3, 4'b0010, 1'b1, 1'b1, 0));
    step(1'b0, 4'b0010, mk(3, 4'b0010, 1'b1, 1'b0, 0));

    // Wrap: 16 write/read pairs carry the pointer through 15 -> 0
    chk_gray = 1'b1;
    rd = 3;
    for (int k = 0; k < 16; k++) begin
      w = (rd + 1) % 16;
      step(1'b0, gray(w), mk(rd % 8, gray(rd), 1'b0, 1'b0, 1));
      step(1'b1, gray(w), mk(w % 8, gray(w), 1'b1, 1'b0, 0));
      rd = w;
    end
    chk_gray = 1'b0;

    // Last-entry race: write arrives the cycle the last entry is read
    step(1'b0, 4'b0110, mk(3, 4'b0010, 1'b0, 1'b0, 1));
    step(1'b1, 4'b0111, mk(4, 4'b0110, 1'b0, 1'b0, 1));
    step(1'b1, 4'b0111, mk(5, 4'b0111, 1'b1, 1'b0, 0));

    // Mid-stream async reset
    step(1'b0, 4'b0100, mk(5, 4'b0111, 1'b0, 1'b0, 2));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compare(900, mk(0, 4'b0000, 1'b1, 1'b0, 0));
    bus.rsync_ptr2 = 4'b0000;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full FIFO level, then drain through almost-empty and raddr wrap
    step(1'b0, 4'b1100, mk(0, 4'b0000, 1'b0, 1'b0, 8));
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 4'b1100, mk(k, gray(k), 1'b0, 1'b0, 8 - k));
    end
    step(1'b1, 4'b1100, mk(0, 4'b1100, 1'b1, 1'b0, 0));
    step(1'b0, 4'b1100, mk(0, 4'b1100, 1'b1, 1'b0, 0));

    for (int t = 0; t < 5 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expectations want 0", sb.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
